regfile_write_ctrl: RTL
=======================

// Module: regfile_write_ctrl
// PURPOSE
//  Writeback stage of the MIPS pipeline and the sole driver of the register file write port (WriteEnable/WriteReg/WriteData).
//  After reset it sweeps every register to INIT_VALUE. It then registers MEM-stage results, selects ALU or load data, and issues exactly one write per retired instruction.
//  It exports a one-cycle bypass of the last committed write. This covers reads that sample the register file on the same edge as the write, which return stale data.
// PARAMETERS
//  DATA_W      32  register/data width
//  ADDR_W      5   register index width
//  NUM_REGS    32  registers cleared by init sweep (<= 2**ADDR_W)
//  INIT_VALUE  0   value written to every register during init
// PORTS
//  CLK          in   1       clock; all state updates on posedge
//  RST_N        in   1       synchronous, active-low reset
//  InValid      in   1       MEM stage holds a retiring instruction
//  InRegWrite   in   1       instruction writes a register
//  InMemToReg   in   1       1: write InMemData, 0: write InAluResult
//  InDestReg    in   ADDR_W  destination register index
//  InAluResult  in   DATA_W  ALU result
//  InMemData    in   DATA_W  load data
//  Stall        in   1       hold: do not capture inputs this cycle
//  Flush        in   1       kill the instruction presented this cycle
//  WriteEnable  out  1       register file write enable
//  WriteReg     out  ADDR_W  register file write index
//  WriteData    out  DATA_W  register file write data
//  BypassValid  out  1       write committed at the last edge
//  BypassReg    out  ADDR_W  its index
//  BypassData   out  DATA_W  its data
//  InitDone     out  1       init sweep finished
//  Busy         out  1       in INIT; upstream must stall
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset, RST_N low at posedge:
//    - state<=INIT, sweep counter<=0.
//    - WriteEnable, WriteReg, WriteData, Bypass*, InitDone <= 0; Busy <= 1.
//    - Applies in any state, including mid-sweep; the sweep always restarts at register 0.
//  - INIT state:
//    - Each cycle: WriteEnable=1, WriteReg=counter, WriteData=INIT_VALUE; counter+1.
//    - After issuing index NUM_REGS-1: state<=RUN, InitDone<=1, Busy<=0.
//    - Exactly NUM_REGS consecutive write cycles.
//    - In*, Stall and Flush are ignored.
//  - RUN state, priority Flush > Stall > capture:
//    - Flush: WriteEnable<=0. The input is discarded.
//    - Stall (no Flush): WriteEnable<=0. The input is not captured. WriteReg/WriteData hold.
//    - Capture: WriteEnable <= InValid & InRegWrite & (InDestReg!=0).
//      - WriteReg <= InDestReg.
//      - WriteData <= InMemToReg ? InMemData : InAluResult.
//  - Latency:
//    - Inputs sampled at edge N drive the write port during cycle N..N+1.
//    - The register file commits at edge N+1.
//    - Each retired instruction asserts WriteEnable for exactly one cycle; a held stall never re-issues a write.
//  - Register 0:
//    - Never written in RUN, regardless of InRegWrite.
//    - The init sweep does write index 0 with INIT_VALUE.
//  - Bypass:
//    - At every posedge: BypassValid<=WriteEnable, BypassReg<=WriteReg, BypassData<=WriteData.
//    - Bypass is valid the cycle after the write is committed.
//    - It covers INIT writes too.
//    - Flush does not clear Bypass, because the write has already committed.
//  - Back-to-back writes to the same register are both issued in order; the last one wins.
//  - No width conversion: data passes unmodified.
// TESTING
//  1. RST_N low 2 cycles, then high -> 32 cycles WE=1, WriteReg 0..31, WriteData=0; then InitDone=1, Busy=0, WE=0.
//  2. RUN, Dest=5, MemToReg=0, Alu=0xDEADBEEF, InValid=RegWrite=1 -> next cycle WE=1, Reg=5, Data=0xDEADBEEF for 1 cycle; cycle after, BypassValid=1, BypassReg=5.
//  3. Dest=8, MemToReg=1, Mem=0x12345678, Alu=0x4 -> WE=1, Reg=8, Data=0x12345678.
//  4. Dest=0, RegWrite=1 -> WE stays 0. RegWrite=0, Dest=9 -> WE stays 0.
//  5. Stall=1 for 3 cycles with Dest=3 on inputs -> WE=0 throughout; release -> one WE pulse to reg 3.
//     Stall=Flush=1 -> WE=0 and the input is lost.
//  6. RST_N low at sweep index 10 -> WE=0 during reset; after release the sweep restarts at index 0 and runs the full 32 cycles.

Source files
------------

// File: rtl/regfile_write_ctrl.sv
// Writeback stage: clears the register file after reset, then issues one register
// write per retired MEM-stage instruction and exposes a bypass of the last commit.
module regfile_write_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_REGS = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              InValid,
  input  logic              InRegWrite,
  input  logic              InMemToReg,
  input  logic [ADDR_W-1:0] InDestReg,
  input  logic [DATA_W-1:0] InAluResult,
  input  logic [DATA_W-1:0] InMemData,
  input  logic              Stall,
  input  logic              Flush,
  output logic              WriteEnable,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic              BypassValid,
  output logic [ADDR_W-1:0] BypassReg,
  output logic [DATA_W-1:0] BypassData,
  output logic              InitDone,
  output logic              Busy
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t              state, stateNext;
  logic [ADDR_W-1:0]   sweepCnt, sweepCntNext;
  logic                weNext;
  logic [ADDR_W-1:0]   regNext;
  logic [DATA_W-1:0]   dataNext;
  logic                doneNext;
  logic                busyNext;

  function automatic logic [DATA_W-1:0] selectData(input logic memToReg,
                                                   input logic [DATA_W-1:0] memData,
                                                   input logic [DATA_W-1:0] aluResult);
    return memToReg ? memData : aluResult;
  endfunction

  always_comb begin
    stateNext    = state;
    sweepCntNext = sweepCnt;
    weNext       = 1'b0;
    regNext      = WriteReg;
    dataNext     = WriteData;
    doneNext     = InitDone;
    busyNext     = Busy;
    case (state)
      INIT: begin
        weNext       = 1'b1;
        regNext      = sweepCnt;
        dataNext     = INIT_VALUE;
        sweepCntNext = sweepCnt + 1'b1;
        if (sweepCnt == LAST_IDX) begin
          stateNext    = RUN;
          sweepCntNext = '0;
          doneNext     = 1'b1;
          busyNext     = 1'b0;
        end
      end
      RUN: begin
        // Flush and Stall both suppress the write; only a clean cycle captures.
        if (!Flush && !Stall) begin
          weNext   = InValid & InRegWrite & (InDestReg != '0);
          regNext  = InDestReg;
          dataNext = selectData(InMemToReg, InMemData, InAluResult);
        end
      end
      default: stateNext = INIT;
    endcase
  end

  // Writeback register stage
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state       <= INIT;
      sweepCnt    <= '0;
      WriteEnable <= 1'b0;
      WriteReg    <= '0;
      WriteData   <= '0;
      BypassValid <= 1'b0;
      BypassReg   <= '0;
      BypassData  <= '0;
      InitDone    <= 1'b0;
      Busy        <= 1'b1;
    end else begin
      state       <= stateNext;
      sweepCnt    <= sweepCntNext;
      WriteEnable <= weNext;
      WriteReg    <= regNext;
      WriteData   <= dataNext;
      BypassValid <= WriteEnable;
      BypassReg   <= WriteReg;
      BypassData  <= WriteData;
      InitDone    <= doneNext;
      Busy        <= busyNext;
    end
  end

endmodule
